// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - control FSM for the multi-cycle MIPS datapath
//
// Purpose: sequences FETCH, DECODE, EXEC, MEM, WB (and TRAP when the
// CTRL_ILLEGAL_TRAP_EN macro is defined) over one shared memory port with a
// ready handshake, and decodes the instruction register into per-cycle
// datapath strobes and mux selects.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   instruction           IR contents, valid from DECODE onward
//   cmp_eq, rs_neg,       datapath comparator flags for branch resolution
//   rs_zero
//   mem_ready             memory completes the current access this cycle
//   mem_req, mem_we,      memory request, write enable, address select
//   mem_addr_sel            (0 = PC, 1 = ALUOut)
//   ir_write, pc_write,   IR load, PC load, PC source select
//   pc_src
//   reg_write, reg_dst,   register file write, destination and data selects
//   wb_sel
//   alu_src_b, alu_op     ALU operand B select and operation
//   epc_write             capture faulting PC (trap build only, else 0)
//   illegal, instr_done   one-cycle event pulses
//   state                 current state, for debug
//
// Configuration macro: CTRL_ILLEGAL_TRAP_EN adds the TRAP state.

module mips_multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        cmp_eq,
  input  logic        rs_neg,
  input  logic        rs_zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_write,
  output logic        pc_write,
  output logic [2:0]  pc_src,
  output logic        reg_write,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wb_sel,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_op,
  output logic        epc_write,
  output logic        illegal,
  output logic        instr_done,
  output logic [2:0]  state
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam logic [2:0] S_TRAP   = 3'd5;
  localparam logic [2:0] PC_TRAP  = 3'd4;
`endif

  localparam logic [2:0] PC_PLUS4  = 3'd0;
  localparam logic [2:0] PC_BRANCH = 3'd1;
  localparam logic [2:0] PC_JUMP   = 3'd2;
  localparam logic [2:0] PC_RS     = 3'd3;

  localparam logic [1:0] REG_RT  = 2'd0;
  localparam logic [1:0] REG_RD  = 2'd1;
  localparam logic [1:0] REG_R31 = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] SRCB_RT    = 2'd0;
  localparam logic [1:0] SRCB_SIMM  = 2'd1;
  localparam logic [1:0] SRCB_ZIMM  = 2'd2;
  localparam logic [1:0] SRCB_SHAMT = 2'd3;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;

  // Instruction classes: they decide the path through EXEC/MEM/WB.
  localparam logic [3:0] CLS_NONE = 4'd0;
  localparam logic [3:0] CLS_ALU  = 4'd1;
  localparam logic [3:0] CLS_LW   = 4'd2;
  localparam logic [3:0] CLS_SW   = 4'd3;
  localparam logic [3:0] CLS_BR   = 4'd4;
  localparam logic [3:0] CLS_J    = 4'd5;
  localparam logic [3:0] CLS_JAL  = 4'd6;
  localparam logic [3:0] CLS_JR   = 4'd7;
  localparam logic [3:0] CLS_JALR = 4'd8;

  logic [2:0] state_q, state_d;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rt;
  logic       is_rtype;
  logic [3:0] cls;
  logic [3:0] dec_op;
  logic [1:0] dec_srcb;
  logic       br_taken;
  logic       unused_instr_bits;

  assign opcode   = instruction[31:26];
  assign funct    = instruction[5:0];
  assign rt       = instruction[20:16];
  assign is_rtype = (opcode == 6'h00);

  // Register numbers other than rt and the immediate value are datapath-only.
  assign unused_instr_bits = ^{instruction[25:21], instruction[15:6]};

  // Decode is purely a function of the IR, so alu_op/alu_src_b stay stable
  // from EXEC through WB while the IR holds the same instruction.
  always_comb begin
    cls      = CLS_NONE;
    dec_op   = ALU_ADD;
    dec_srcb = SRCB_RT;
    br_taken = 1'b0;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20, 6'h21: begin cls = CLS_ALU; dec_op = ALU_ADD;  end
          6'h22, 6'h23: begin cls = CLS_ALU; dec_op = ALU_SUB;  end
          6'h24:        begin cls = CLS_ALU; dec_op = ALU_AND;  end
          6'h25:        begin cls = CLS_ALU; dec_op = ALU_OR;   end
          6'h26:        begin cls = CLS_ALU; dec_op = ALU_XOR;  end
          6'h27:        begin cls = CLS_ALU; dec_op = ALU_NOR;  end
          6'h2a:        begin cls = CLS_ALU; dec_op = ALU_SLT;  end
          6'h2b:        begin cls = CLS_ALU; dec_op = ALU_SLTU; end
          6'h00: begin cls = CLS_ALU; dec_op = ALU_SLL; dec_srcb = SRCB_SHAMT; end
          6'h02: begin cls = CLS_ALU; dec_op = ALU_SRL; dec_srcb = SRCB_SHAMT; end
          6'h03: begin cls = CLS_ALU; dec_op = ALU_SRA; dec_srcb = SRCB_SHAMT; end
          6'h08: cls = CLS_JR;
          6'h09: cls = CLS_JALR;
          default: cls = CLS_NONE;
        endcase
      end
      6'h23: begin cls = CLS_LW;  dec_op = ALU_ADD;  dec_srcb = SRCB_SIMM; end
      6'h2b: begin cls = CLS_SW;  dec_op = ALU_ADD;  dec_srcb = SRCB_SIMM; end
      6'h0f: begin cls = CLS_ALU; dec_op = ALU_LUI;  dec_srcb = SRCB_SIMM; end
      6'h08, 6'h09: begin cls = CLS_ALU; dec_op = ALU_ADD; dec_srcb = SRCB_SIMM; end
      6'h0c: begin cls = CLS_ALU; dec_op = ALU_AND;  dec_srcb = SRCB_ZIMM; end
      6'h0a: begin cls = CLS_ALU; dec_op = ALU_SLT;  dec_srcb = SRCB_SIMM; end
      6'h0b: begin cls = CLS_ALU; dec_op = ALU_SLTU; dec_srcb = SRCB_SIMM; end
      6'h04: begin cls = CLS_BR; dec_op = ALU_SUB; br_taken = cmp_eq;  end
      6'h05: begin cls = CLS_BR; dec_op = ALU_SUB; br_taken = !cmp_eq; end
      6'h06: begin cls = CLS_BR; dec_op = ALU_SUB; br_taken = rs_neg | rs_zero; end
      6'h07: begin cls = CLS_BR; dec_op = ALU_SUB; br_taken = !(rs_neg | rs_zero); end
      6'h01: begin
        // REGIMM: only rt = 0 (bltz) is supported; bgez and friends trap.
        if (rt == 5'd0) begin
          cls      = CLS_BR;
          dec_op   = ALU_SUB;
          br_taken = rs_neg;
        end
      end
      6'h02: cls = CLS_J;
      6'h03: cls = CLS_JAL;
      default: cls = CLS_NONE;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_PLUS4;
    reg_write    = 1'b0;
    reg_dst      = REG_RT;
    wb_sel       = WB_ALU;
    epc_write    = 1'b0;
    illegal      = 1'b0;
    instr_done   = 1'b0;
    alu_op       = dec_op;
    alu_src_b    = dec_srcb;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = PC_PLUS4;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (cls == CLS_NONE) begin
          illegal = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          instr_done = 1'b1;
          state_d    = S_FETCH;
`endif
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls)
          CLS_BR: begin
            pc_write   = br_taken;
            pc_src     = PC_BRANCH;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          CLS_J, CLS_JAL: begin
            pc_write   = 1'b1;
            pc_src     = PC_JUMP;
            reg_write  = (cls == CLS_JAL);
            reg_dst    = REG_R31;
            wb_sel     = WB_PC4;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          CLS_JR, CLS_JALR: begin
            pc_write   = 1'b1;
            pc_src     = PC_RS;
            reg_write  = (cls == CLS_JALR);
            reg_dst    = REG_RD;
            wb_sel     = WB_PC4;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          CLS_LW, CLS_SW: state_d = S_MEM;
          CLS_ALU:        state_d = S_WB;
          default: begin
            // IR changed under us after DECODE; retire as a NOP.
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (cls == CLS_SW);
        if (mem_ready) begin
          if (cls == CLS_SW) begin
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = is_rtype ? REG_RD : REG_RT;
        wb_sel     = (cls == CLS_LW) ? WB_MEM : WB_ALU;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_TRAP: begin
        epc_write  = 1'b1;
        pc_write   = 1'b1;
        pc_src     = PC_TRAP;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
`endif
      default: state_d = S_FETCH;
    endcase

    // Reset kills every strobe in the same cycle, including a pending access.
    if (reset) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      epc_write  = 1'b0;
      illegal    = 1'b0;
      instr_done = 1'b0;
      state_d    = S_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Control FSM for the multi-cycle MIPS datapath. It sequences fetch, decode, execute, memory and writeback over one shared memory port with a ready handshake. It decodes the instruction register into per-cycle datapath strobes and mux selects. It recognises the same instruction set the CPU decodes: lw, sw, lui, addi, addiu, andi, slti, sltiu, beq, bne, blez, bgtz, bltz, j, jal, and R-type add through slt plus jr and jalr.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- instruction  in  32  IR contents, valid from DECODE onward.
- cmp_eq  in  1  rs == rt from the datapath comparator.
- rs_neg  in  1  rs[31].
- rs_zero  in  1  rs == 0.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  write access (sw only).
- mem_addr_sel  out  1  0 = PC, 1 = ALUOut.
- ir_write  out  1  load IR from memory read data.
- pc_write  out  1  load PC.
- pc_src  out  3  0 = PC+4, 1 = branch target, 2 = jump target, 3 = rs, 4 = trap vector.
- reg_write  out  1  register file write.
- reg_dst  out  2  0 = rt, 1 = rd, 2 = r31.
- wb_sel  out  2  0 = ALUOut, 1 = memory data, 2 = PC+4.
- alu_src_b  out  2  0 = rt, 1 = sign-extended imm16, 2 = zero-extended imm16, 3 = shamt.
- alu_op  out  4  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 nor, 6 slt, 7 sltu, 8 sll, 9 srl, 10 sra, 11 lui.
- epc_write  out  1  capture the faulting PC.
- illegal  out  1  one-cycle pulse on an unrecognised opcode or funct.
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
- state  out  3  current state, for debug.

## Operation
- State encoding: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 5.
- Outputs are combinational from the state register and `instruction`.
- While `reset` is high, every strobe is 0 (mem_req, ir_write, pc_write, reg_write, epc_write, illegal, instr_done).
- **FETCH:** assert mem_req with mem_addr_sel = 0.
  - On mem_ready, assert ir_write and pc_write with pc_src = 0, then go to DECODE.
  - Otherwise stay in FETCH.
- **DECODE:** one cycle, no strobes.
  - Recognised instructions go to EXEC.
  - Unrecognised instructions assert illegal and instr_done, then go to FETCH (treated as a NOP).
- **EXEC:** alu_op and alu_src_b are driven per instruction.
  - andi uses alu_src_b = 2. sll, srl and sra use alu_src_b = 3.
  - **Branches:** taken when beq & cmp_eq, bne & !cmp_eq, blez & (rs_neg | rs_zero), bgtz & !(rs_neg | rs_zero), or bltz & rs_neg. When taken, assert pc_write with pc_src = 1. Assert instr_done and go to FETCH.
  - **j / jal:** pc_write with pc_src = 2. jal also asserts reg_write with reg_dst = 2 and wb_sel = 2. Assert instr_done and go to FETCH.
  - **jr / jalr:** pc_write with pc_src = 3. jalr also asserts reg_write with reg_dst = 1 and wb_sel = 2. Assert instr_done and go to FETCH.
  - **lw / sw:** alu_op = 0, alu_src_b = 1, go to MEM.
  - **Everything else:** go to WB.
- **MEM:** assert mem_req with mem_addr_sel = 1; mem_we = 1 for sw.
  - On mem_ready: lw goes to WB; sw asserts instr_done and goes to FETCH.
  - Otherwise hold in MEM.
- **WB:** assert reg_write; reg_dst = 1 for R-type, otherwise 0; wb_sel = 1 for lw, otherwise 0.
  - Assert instr_done and go to FETCH.
- alu_op and alu_src_b stay stable from EXEC through WB for the same instruction.

## Timing
Latencies below assume zero-wait memory; each cycle mem_ready is low adds one cycle.
- R-type and immediate ALU instructions: 4 cycles.
- lw: 5 cycles.
- sw: 4 cycles.
- Branches and jumps: 3 cycles.
- Illegal instruction: 2 cycles without the trap feature, 3 with it.

Boundary rules:
- The first cycle after reset falls is FETCH with mem_req = 1.
- Reset asserted during a pending memory access: mem_req is 0 in that same cycle, and the state is FETCH after the edge.
- mem_ready is ignored outside FETCH and MEM.
- mem_req is held high until mem_ready is seen.
- instr_done and illegal never last longer than one cycle.

## Configuration
- **CTRL_ILLEGAL_TRAP_EN defined:** an unrecognised instruction goes DECODE -> TRAP instead of back to FETCH.
  - TRAP is one cycle asserting epc_write, pc_write with pc_src = 4, and instr_done; then FETCH.
  - illegal still pulses in DECODE.
- **CTRL_ILLEGAL_TRAP_EN undefined:** the TRAP state is absent, epc_write is tied to 0, and an illegal instruction behaves as a NOP.

## Test plan
- add $3,$1,$2 (0x00221820) with mem_ready always 1 → states 0, 1, 2, 4; reg_write = 1 with reg_dst = 1 in cycle 4; instr_done in cycle 4.
- lw $5,8($4) (0x8C850008) with mem_ready low for 2 cycles in MEM → MEM held 3 cycles, mem_addr_sel = 1; WB with wb_sel = 1; 7 cycles total.
- beq with cmp_eq = 1 → pc_write = 1 and pc_src = 1 in EXEC. Same instruction with cmp_eq = 0 → pc_write = 0 in EXEC; 3 cycles either way.
- jal (0x0C000010) → in EXEC: pc_src = 2, reg_write = 1, reg_dst = 2, wb_sel = 2.
- Opcode 0x3F → illegal pulses in DECODE. Without the macro, the next state is FETCH. With the macro, TRAP follows with epc_write = 1 and pc_src = 4.
- Reset raised in MEM while sw has mem_req = 1 → mem_req is 0 that cycle and state = 0 after the edge; no mem_we pulse.
